// File: rtl/wbuf_pkg.sv
// Shared types and default sizes for the data-cache write buffer.
package wbuf_pkg;

  localparam int DEF_DEPTH  = 4;
  localparam int DEF_ADDR_W = 28;
  localparam int DEF_LINE_W = 128;

  typedef enum logic [1:0] {
    IDLE,
    RD_MEM,
    WR_MEM,
    RESP
  } wbuf_state_e;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_LINE_W-1:0] data;
  } wbuf_entry_t;

endpackage

// File: rtl/wbuf_cam.sv
// Write-buffer entry storage with a parallel address compare that reports the youngest valid hit.
module wbuf_cam
  import wbuf_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LINE_W = DEF_LINE_W,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [PTR_W-1:0]  widx_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [LINE_W-1:0] wdata_i,
  input  logic [PTR_W-1:0]  head_i,
  input  logic [PTR_W:0]    count_i,
  input  logic              skip_head_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              hit,
  output logic [PTR_W-1:0]  hit_idx,
  output logic [LINE_W-1:0] hit_data,
  output logic [ADDR_W-1:0] head_addr_o,
  output logic [LINE_W-1:0] head_data_o
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] data;
  } entry_t;

  entry_t            entries_q [DEPTH];
  logic [PTR_W-1:0]  idx;

  always_ff @(posedge clk) begin
    if (we_i) entries_q[widx_i] <= '{addr: waddr_i, data: wdata_i};
  end

  // Walk from oldest to youngest so the last matching entry wins.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    hit_data = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_i + PTR_W'(k);
      if (((PTR_W+1)'(k) < count_i) && (entries_q[idx].addr == addr_i) &&
          !(skip_head_i && (k == 0))) begin
        hit      = 1'b1;
        hit_idx  = idx;
        hit_data = entries_q[idx].data;
      end
    end
  end

  assign head_addr_o = entries_q[head_i].addr;
  assign head_data_o = entries_q[head_i].data;

endmodule

// File: rtl/dcache_write_buffer.sv
// Write buffer between the data cache and memory: absorbs write-backs, drains them, forwards to reads.
// Define WBUF_MERGE_EN to merge writes into a matching non-draining entry instead of allocating.
module dcache_write_buffer
  import wbuf_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LINE_W = DEF_LINE_W
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              c_read,
  input  logic              c_write,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [LINE_W-1:0] c_wdata,
  output logic [LINE_W-1:0] c_rdata,
  output logic              c_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam int PTR_W = $clog2(DEPTH);

  wbuf_state_e       state_q, state_d;
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              c_ready_q, c_ready_d;
  logic [LINE_W-1:0] c_rdata_q, c_rdata_d;
  logic              mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;

  logic              rd_req, wr_req, drain_start, pop, push, full;
  logic              skip_head, merge_hit, cam_we;
  logic              hit;
  logic [PTR_W-1:0]  hit_idx;
  logic [LINE_W-1:0] hit_data;
  logic [ADDR_W-1:0] head_addr;
  logic [LINE_W-1:0] head_data;

  // Requests seen while c_ready is high are the tail of an already-served handshake.
  always_comb begin
    rd_req      = c_read && !c_ready_q;
    wr_req      = c_write && !c_read && !c_ready_q;
    drain_start = (state_q == IDLE) && !c_read && (count_q != '0);
    pop         = (state_q == WR_MEM) && mem_ready;
    full        = (count_q == (PTR_W+1)'(DEPTH));
`ifdef WBUF_MERGE_EN
    skip_head   = wr_req && ((state_q == WR_MEM) || drain_start);
    merge_hit   = wr_req && hit;
`else
    skip_head   = 1'b0;
    merge_hit   = 1'b0;
`endif
    push        = wr_req && !merge_hit && (!full || pop);
    cam_we      = push || merge_hit;
  end

  wbuf_cam #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .LINE_W(LINE_W),
    .PTR_W (PTR_W)
  ) u_cam (
    .clk        (clk),
    .we_i       (cam_we),
    .widx_i     (merge_hit ? hit_idx : tail_q),
    .waddr_i    (c_addr),
    .wdata_i    (c_wdata),
    .head_i     (head_q),
    .count_i    (count_q),
    .skip_head_i(skip_head),
    .addr_i     (c_addr),
    .hit        (hit),
    .hit_idx    (hit_idx),
    .hit_data   (hit_data),
    .head_addr_o(head_addr),
    .head_data_o(head_data)
  );

  always_comb begin
    state_d     = state_q;
    c_ready_d   = 1'b0;
    c_rdata_d   = c_rdata_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    head_d      = head_q + PTR_W'(pop);
    tail_d      = tail_q + PTR_W'(push);
    count_d     = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);

    if (cam_we) c_ready_d = 1'b1;
    // A draining head is still valid, so reads may forward from it while WR_MEM is in flight.
    if (rd_req && hit && ((state_q == IDLE) || (state_q == WR_MEM))) begin
      c_ready_d = 1'b1;
      c_rdata_d = hit_data;
    end

    case (state_q)
      IDLE: begin
        if (rd_req && !hit) begin
          state_d    = RD_MEM;
          mem_read_d = 1'b1;
          mem_addr_d = c_addr;
        end else if (drain_start) begin
          state_d     = WR_MEM;
          mem_write_d = 1'b1;
          mem_addr_d  = head_addr;
          mem_wdata_d = head_data;
        end
      end
      RD_MEM: begin
        if (mem_ready) begin
          state_d    = RESP;
          mem_read_d = 1'b0;
          c_ready_d  = 1'b1;
          c_rdata_d  = mem_rdata;
        end
      end
      WR_MEM: begin
        if (mem_ready) begin
          state_d     = IDLE;
          mem_write_d = 1'b0;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q     <= IDLE;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      c_ready_q   <= 1'b0;
      c_rdata_q   <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      c_ready_q   <= c_ready_d;
      c_rdata_q   <= c_rdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign c_ready   = c_ready_q;
  assign c_rdata   = c_rdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dcache_write_buffer.sv
// Scoreboard bench for dcache_write_buffer: cache driver, memory responder and reference model.
module tb_dcache_write_buffer;

  localparam int AW = 28;
  localparam int LW = 128;

  logic          clk;
  logic          proc_reset;
  logic          c_read, c_write;
  logic [AW-1:0] c_addr;
  logic [LW-1:0] c_wdata, c_rdata;
  logic          c_ready;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata, mem_rdata;
  logic          mem_ready;

  dcache_write_buffer dut (
    .clk       (clk),
    .proc_reset(proc_reset),
    .c_read    (c_read),
    .c_write   (c_write),
    .c_addr    (c_addr),
    .c_wdata   (c_wdata),
    .c_rdata   (c_rdata),
    .c_ready   (c_ready),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit            isRd;
    logic [AW-1:0] addr;
    logic [LW-1:0] data;
  } exp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [LW-1:0] data;
  } wr_t;

  typedef struct {
    bit            isWr;
    logic [AW-1:0] addr;
    logic [LW-1:0] data;
  } op_t;

  exp_t          expQ[$];
  wr_t           pendQ[$];
  op_t           opLog[$];
  logic [LW-1:0] refMem [logic [AW-1:0]];

  int            compared = 0;
  int            mismatched = 0;
  int            cycle = 0;
  int            readyCount = 0;
  int            readyCycle = 0;
  int            wrDoneCycle = 0;
  int            memReadCount = 0;
  int            memLatMax = 0;
  int            lat = -1;
  bit            memHold = 1'b1;
  logic [AW-1:0] expRdAddr = '0;
  logic [AW-1:0] lastWrAddr = '0;

  localparam logic [LW-1:0] DA = 128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004;
  localparam logic [LW-1:0] DB = 128'hBBBB_0001_BBBB_0002_BBBB_0003_BBBB_0004;
  localparam logic [LW-1:0] DD = 128'hDDDD_1111_DDDD_2222_DDDD_3333_DDDD_4444;
  localparam logic [LW-1:0] DE = 128'hEEEE_5555_EEEE_6666_EEEE_7777_EEEE_8888;

  initial forever begin
    @(posedge clk);
    cycle++;
  end

  function automatic logic [LW-1:0] memDefault(input logic [AW-1:0] a);
    logic [31:0] w;
    w = 32'(a);
    return {w ^ 32'h1357_9BDF, w ^ 32'h2468_ACE0, w ^ 32'h0F0F_F0F0, w ^ 32'hC0DE_0000};
  endfunction

  // Value memory would hold once every accepted write has landed, in order.
  function automatic logic [LW-1:0] modelRead(input logic [AW-1:0] a);
    for (int i = pendQ.size() - 1; i >= 0; i--)
      if (pendQ[i].addr == a) return pendQ[i].data;
    if (refMem.exists(a)) return refMem[a];
    return memDefault(a);
  endfunction

  task automatic checkOutput(input string name, input logic [LW-1:0] act, input logic [LW-1:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, expv);
    end
  endtask

  task automatic reportTimeout(input string name, input int waited);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: no completion after %0d cycles, required completion", name, waited);
  endtask

  task automatic applyStimulus(input bit isRd, input logic [AW-1:0] a, input logic [LW-1:0] d);
    exp_t e;
    int   n;
    e.isRd = isRd;
    e.addr = a;
    e.data = isRd ? modelRead(a) : '0;
    if (isRd) expRdAddr = a;
    else pendQ.push_back('{addr: a, data: d});
    expQ.push_back(e);
    c_read  = isRd;
    c_write = !isRd;
    c_addr  = a;
    c_wdata = isRd ? '0 : d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!c_ready && n < 400);
    if (!c_ready) begin
      reportTimeout(isRd ? "cache read" : "cache write", n);
      void'(expQ.pop_back());
    end
    c_read  = 1'b0;
    c_write = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((pendQ.size() != 0 || mem_write) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (pendQ.size() != 0 || mem_write) reportTimeout("drain", n);
  endtask

  // Monitor: every c_ready pulse retires the oldest expectation.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (c_ready) begin
      readyCount++;
      readyCycle = cycle;
      if (expQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL spurious c_ready: got 1, required 0 with no request pending");
      end else begin
        e = expQ.pop_front();
        if (e.isRd) checkOutput($sformatf("read data @%h", e.addr), c_rdata, e.data);
      end
    end
  end

  // Main-memory model: completes requests after a random latency unless held.
  initial begin
    wr_t w;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_ready) mem_ready = 1'b0;
      else if (!proc_reset && !memHold && (mem_read || mem_write)) begin
        if (lat < 0) lat = int'($urandom_range(memLatMax, 0));
        if (lat == 0) begin
          lat = -1;
          if (mem_write) begin
            opLog.push_back('{isWr: 1'b1, addr: mem_addr, data: mem_wdata});
            lastWrAddr  = mem_addr;
            wrDoneCycle = cycle;
            if (pendQ.size() == 0) begin
              compared++;
              mismatched++;
              $display("[TB] FAIL drain order: got write @%h, required no write", mem_addr);
            end else begin
              w = pendQ.pop_front();
              checkOutput("drain addr", mem_addr, w.addr);
              checkOutput("drain data", mem_wdata, w.data);
              refMem[w.addr] = w.data;
            end
          end else begin
            opLog.push_back('{isWr: 1'b0, addr: mem_addr, data: '0});
            memReadCount++;
            checkOutput("mem_read addr", mem_addr, expRdAddr);
            mem_rdata = refMem.exists(mem_addr) ? refMem[mem_addr] : memDefault(mem_addr);
          end
          mem_ready = 1'b1;
        end else lat--;
      end
    end
  end

  initial begin
    int rc0, mr0;
    proc_reset = 1'b1;
    c_read = 1'b0;
    c_write = 1'b0;
    c_addr = '0;
    c_wdata = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset c_ready", c_ready, 0);
    checkOutput("reset mem_read", mem_read, 0);
    checkOutput("reset mem_write", mem_write, 0);
    checkOutput("reset c_rdata", c_rdata, 0);
    checkOutput("reset mem_addr", mem_addr, 0);
    checkOutput("reset mem_wdata", mem_wdata, 0);
    proc_reset = 1'b0;
    @(negedge clk);

    $display("[TB] write then forwarded read");
    memHold = 1'b1;
    mr0 = memReadCount;
    applyStimulus(1'b0, 28'h0000010, DA);
    applyStimulus(1'b1, 28'h0000010, 'x);
    checkOutput("forward no mem_read", memReadCount, mr0);
    memHold = 1'b0;
    waitDrain();

    $display("[TB] fill buffer and stall fifth write");
    memHold = 1'b1;
    for (int i = 1; i <= 4; i++) applyStimulus(1'b0, AW'(i), {4{32'(i)}});
    rc0 = readyCount;
    fork
      applyStimulus(1'b0, 28'h5, {4{32'h5}});
      begin
        repeat (6) @(negedge clk);
        checkOutput("full write stalled", readyCount, rc0);
        memHold = 1'b0;
      end
    join
    checkOutput("push in pop cycle", readyCycle, wrDoneCycle + 1);
    checkOutput("first drain addr", lastWrAddr, 28'h1);
    waitDrain();

    $display("[TB] read miss beats drain");
    memHold = 1'b1;
    applyStimulus(1'b0, 28'h1, DD);
    opLog.delete();
    fork
      applyStimulus(1'b1, 28'h99, 'x);
      begin
        repeat (4) @(negedge clk);
        memHold = 1'b0;
      end
    join
    waitDrain();
    checkOutput("op count", opLog.size(), 2);
    if (opLog.size() >= 2) begin
      checkOutput("first op is read", opLog[0].isWr, 0);
      checkOutput("first op addr", opLog[0].addr, 28'h99);
      checkOutput("second op is write", opLog[1].isWr, 1);
      checkOutput("second op addr", opLog[1].addr, 28'h1);
    end

    $display("[TB] duplicate writes forward youngest");
    memHold = 1'b1;
    opLog.delete();
    applyStimulus(1'b0, 28'h5, DA);
    applyStimulus(1'b0, 28'h5, DB);
    applyStimulus(1'b1, 28'h5, 'x);
    memHold = 1'b0;
    waitDrain();
    checkOutput("dup drain count", opLog.size(), 2);
    if (opLog.size() >= 2) begin
      checkOutput("dup drain 1 data", opLog[0].data, DA);
      checkOutput("dup drain 2 data", opLog[1].data, DB);
    end

    $display("[TB] reset during drain");
    memHold = 1'b1;
    applyStimulus(1'b0, 28'h20, DD);
    repeat (3) @(negedge clk);
    checkOutput("drain in flight", mem_write, 1);
    proc_reset = 1'b1;
    @(negedge clk);
    checkOutput("reset mem_write", mem_write, 0);
    checkOutput("reset c_ready", c_ready, 0);
    checkOutput("reset mem_read", mem_read, 0);
    pendQ.delete();
    expQ.delete();
    lat = -1;
    proc_reset = 1'b0;
    memHold = 1'b0;
    @(negedge clk);
    mr0 = memReadCount;
    applyStimulus(1'b1, 28'h20, 'x);
    checkOutput("post-reset read from memory", memReadCount, mr0 + 1);

    $display("[TB] forward from draining head");
    memHold = 1'b1;
    applyStimulus(1'b0, 28'h7, DE);
    repeat (3) @(negedge clk);
    checkOutput("head drain addr", mem_addr, 28'h7);
    mr0 = memReadCount;
    applyStimulus(1'b1, 28'h7, 'x);
    checkOutput("head forward no mem_read", memReadCount, mr0);
    memHold = 1'b0;
    waitDrain();

    $display("[TB] random traffic");
    memLatMax = 3;
    for (int i = 0; i < 300; i++) begin
      logic [AW-1:0] a;
      a = AW'(28'h100 + $urandom_range(5, 0));
      if ($urandom_range(1, 0) == 0) applyStimulus(1'b1, a, 'x);
      else applyStimulus(1'b0, a, {$urandom, $urandom, $urandom, $urandom});
      repeat ($urandom_range(2, 0)) @(negedge clk);
    end
    waitDrain();
    repeat (4) @(negedge clk);
    checkOutput("pending writes left", pendQ.size(), 0);
    checkOutput("expectations left", expQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
